id_ex_stage: RTL

- Parametrised ID/EX pipeline register for the pipelined core; replaces the fixed-width, always-load ID/EX latch.
- Adds a valid bit, a downstream stall (hold), a flush (squash to bubble), built-in load-use hazard detection with automatic bubble insertion, and a saturating bubble counter.
- Sits between the decode/regfile stage and the ALU/EX stage.

---
 rtl/id_ex_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid tracking, downstream hold, flush-to-bubble,
// load-use hazard detection with automatic bubble insertion and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W  = 8,
  parameter int REG_W   = 3,
  parameter int JMP_W   = 16,
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 4,
  parameter int IMM_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic               write_mem_i,
  input  logic               write_reg_i,
  input  logic               read_mem_i,
  input  logic [DATA_W-1:0]  data1_i,
  input  logic [DATA_W-1:0]  data2_i,
  input  logic [DATA_W-1:0]  dataD_i,
  input  logic [REG_W-1:0]   reg1_i,
  input  logic [REG_W-1:0]   reg2_i,
  input  logic [REG_W-1:0]   rd_i,
  input  logic [JMP_W-1:0]   jmpLoc_i,
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic [IMM_W-1:0]   imm_i,
  output logic               stall_o,
  output logic               valid_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               write_mem_o,
  output logic               write_reg_o,
  output logic               read_mem_o,
  output logic [DATA_W-1:0]  data1_o,
  output logic [DATA_W-1:0]  data2_o,
  output logic [DATA_W-1:0]  dataD_o,
  output logic [REG_W-1:0]   reg1_o,
  output logic [REG_W-1:0]   reg2_o,
  output logic [REG_W-1:0]   rd_o,
  output logic [JMP_W-1:0]   jmpLoc_o,
  output logic [OPC_W-1:0]   opcode_o,
  output logic [IMM_W-1:0]   imm_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic hazard;
  logic advance;
  logic load_fields;
  logic take_ctrl;

  always_comb begin
    hazard      = valid_o & read_mem_o & write_reg_o & valid_i &
                  ((rd_o == reg1_i) | (rd_o == reg2_i));
    advance     = flush_i | ~stall_i;
    load_fields = flush_i | (~stall_i & ~hazard);
    // Control only survives a normal load of a real instruction; flush and bubble zero it.
    take_ctrl   = ~flush_i & ~hazard & valid_i;
  end

  assign stall_o = ~flush_i & (stall_i | hazard);

  // ID -> EX register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o      <= 1'b0;
      write_mem_o  <= 1'b0;
      write_reg_o  <= 1'b0;
      read_mem_o   <= 1'b0;
      alu_op_o     <= '0;
      data1_o      <= '0;
      data2_o      <= '0;
      dataD_o      <= '0;
      reg1_o       <= '0;
      reg2_o       <= '0;
      rd_o         <= '0;
      jmpLoc_o     <= '0;
      opcode_o     <= '0;
      imm_o        <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (advance) begin
        valid_o     <= take_ctrl;
        write_mem_o <= take_ctrl & write_mem_i;
        write_reg_o <= take_ctrl & write_reg_i;
        read_mem_o  <= take_ctrl & read_mem_i;
      end
      if (load_fields) begin
        alu_op_o <= alu_op_i;
        data1_o  <= data1_i;
        data2_o  <= data2_i;
        dataD_o  <= dataD_i;
        reg1_o   <= reg1_i;
        reg2_o   <= reg2_i;
        rd_o     <= rd_i;
        jmpLoc_o <= jmpLoc_i;
        opcode_o <= opcode_i;
        imm_o    <= imm_i;
      end
      if (~flush_i & ~stall_i & hazard)
        bubble_cnt_o <= sat_inc(bubble_cnt_o);
    end
  end

endmodule
